pentary_weight_loader: RTL and testbench
========================================

# pentary_weight_loader

- Upstream of the memristor crossbar controller. Streams pentary weights into a rectangular region of the 256×256 crossbar.
- Accepts 3-bit pentary digits on a valid/ready stream and issues one crossbar write per digit, in row-major order.
- Paces writes to the controller's `ready`. Substitutes zero for illegal digit codes and reports them.

## Interface
Parameters:
- `DIM`, 256: crossbar rows = columns.
- `AW`, 8: address width, log2(DIM).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a load; sampled only in IDLE.
- `base_row` in AW, `base_col` in AW: region origin; captured on accepted `start`.
- `num_rows` in AW+1, `num_cols` in AW+1: region size, 0..DIM; captured on accepted `start`.
- `s_valid` in 1, `s_ready` out 1, `s_pent` in 3: weight stream.
  - Encoding: 000=-2, 001=-1, 010=0, 011=+1, 100=+2.
  - Codes 101–111 are illegal.
- `xb_row_select` out AW, `xb_col_select` out AW, `xb_write_value` out 3, `xb_write_enable` out 1: to the crossbar controller.
- `xb_ready` in 1: controller idle.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse at load end.
- `bad_pent` out 1: sticky; set if any illegal code was accepted since the last `start`.
- `wr_count` out 2·AW+1: writes issued since the last `start`.

## Operation
States: IDLE, FETCH, ISSUE, WAIT, FIN.

- **IDLE**
  - `start`=1 with `num_rows`=0 or `num_cols`=0 → FIN; no writes.
  - `start`=1 otherwise → FETCH.
  - On an accepted `start`: capture base and size, set row/col offsets to 0, clear `wr_count` and `bad_pent`.
- **FETCH**
  - `s_ready`=1.
  - On `s_valid`: latch the digit into the write-value register, then → ISSUE.
  - An illegal code is latched as 010 and sets `bad_pent`.
- **ISSUE**
  - `xb_write_enable` = `xb_ready` (combinational, gated low while `reset`=1).
  - If `xb_ready`=1 → WAIT and increment `wr_count`.
  - Otherwise stay in ISSUE; the write is held, not dropped.
- **WAIT**
  - Wait for the controller to return to idle: needs at least one cycle with `xb_ready`=0 seen, or one elapsed cycle, then `xb_ready`=1.
  - Then advance the address:
    - col_off+1.
    - If col_off reaches `num_cols`-1: col_off←0, row_off+1.
  - If the last element was written → FIN, else → FETCH.
- **FIN**
  - `done`=1 for one cycle, then → IDLE.

Address generation:
- `xb_row_select` = (base_row+row_off) mod DIM; `xb_col_select` = (base_col+col_off) mod DIM.
- Address arithmetic is AW-bit wrapping; a region crossing index 255 wraps to 0.

Other rules:
- `start` outside IDLE is ignored.
- `s_ready`=0 in every state except FETCH.
- Address and value outputs are registered and stable throughout ISSUE and WAIT.

## Timing
Reset values:
- state IDLE.
- `s_ready` 0, `xb_write_enable` 0, `busy` 0, `done` 0, `bad_pent` 0, `wr_count` 0.
- `xb_row_select` 0, `xb_col_select` 0, `xb_write_value` 010.

Reset mid-load:
- State returns to IDLE at the next edge.
- `xb_write_enable` is forced low in the reset cycle.
- No `done` is produced.
- Crossbar contents already written are not rolled back.

Cycle timing:
- `start` sampled at edge 0 → `s_ready`=1 in cycle 1.
- With `s_valid` and `xb_ready` constantly high: one write per 3 cycles.
  - Sequence: FETCH, ISSUE, WAIT.
  - `xb_write_enable` is high in cycles 2, 5, 8, ….
- `done` is high the cycle after the final WAIT exits.
- Load of N weights, no stalls: `done` in cycle 3N+1.
- Zero-size load: `done` in cycle 1.

Stalls:
- `xb_ready`=0 in ISSUE extends ISSUE with no write.
- `s_valid`=0 in FETCH extends FETCH.

## Structure
- Shared package `pentary_pkg`: pent type (3 bits); constants PENT_NEG2..PENT_POS2; `pent_is_valid` function.
- The crossbar controller imports `pentary_pkg` for the same encodings.
- One sub-module `pentary_region_addr_gen`:
  - Row/col offset counters with load/advance/last outputs.
  - Wrapped address add.
- FSM, stream capture and counters live in the top module.

## Test plan
- Base (0,0), size 2×3, stream +2,+1,0,-1,-2,+1, `xb_ready` always 1:
  - Writes (0,0)=100, (0,1)=011, (0,2)=010, (1,0)=001, (1,1)=000, (1,2)=011.
  - `done` in cycle 19; `wr_count`=6; `bad_pent`=0.
- Base (255,254), size 2×3:
  - Column order 254, 255, 0 on rows 255, then 0.
  - Six writes, addresses wrapped.
- `s_pent`=111 in the middle of a 1×3 load:
  - That write carries 010.
  - `bad_pent`=1 until the next `start`; it still reads 1 after `done`.
- Controller busy:
  - `xb_ready` held 0 for 10 cycles while in ISSUE → `xb_write_enable` stays 0, state holds.
  - Exactly one write when `xb_ready` returns to 1.
- Edge cases:
  - `num_cols`=0 → `done` in cycle 1, zero writes.
  - `start` pulsed while busy → ignored, `wr_count` unaffected.
- `reset` asserted in ISSUE → `xb_write_enable` 0 that cycle; all outputs at reset values next cycle; no `done`.

Source files
------------

// File: rtl/pentary_pkg.sv
// Shared pentary encodings and loader state type.
// Used by the weight loader and the crossbar controller.
package pentary_pkg;

    typedef logic [2:0] pent_t;

    localparam pent_t PENT_NEG2 = 3'b000;
    localparam pent_t PENT_NEG1 = 3'b001;
    localparam pent_t PENT_ZERO = 3'b010;
    localparam pent_t PENT_POS1 = 3'b011;
    localparam pent_t PENT_POS2 = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT,
        ST_FIN
    } ld_state_t;

    function automatic logic pent_is_valid(pent_t p);
        return p <= PENT_POS2;
    endfunction

endpackage

// File: rtl/pentary_weight_loader_if.sv
// Pentary weight stream handshake bundle.
// The source drives valid/digit, the sink drives ready.
interface pentary_weight_loader_if;
    import pentary_pkg::*;

    logic  s_valid;
    logic  s_ready;
    pent_t s_pent;

    modport master (
        output s_valid,
        output s_pent,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_pent,
        output s_ready
    );

endinterface

// File: rtl/pentary_region_addr_gen.sv
// Row-major offset walker over a crossbar region.
// Produces wrapped row/col addresses from captured origin.
module pentary_region_addr_gen #(
    parameter int DIM = 256,
    parameter int AW  = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          advance,
    input  logic [AW-1:0] base_row,
    input  logic [AW-1:0] base_col,
    input  logic [AW:0]   num_rows,
    input  logic [AW:0]   num_cols,
    output logic [AW-1:0] row_sel,
    output logic [AW-1:0] col_sel,
    output logic          last
);

    logic [AW-1:0] base_row_q;
    logic [AW-1:0] base_col_q;
    logic [AW:0]   nrows_q;
    logic [AW:0]   ncols_q;
    logic [AW-1:0] row_off;
    logic [AW-1:0] col_off;
    logic          col_last;
    logic          row_last;

    assign col_last = ({1'b0, col_off} == ncols_q - (AW+1)'(1));
    assign row_last = ({1'b0, row_off} == nrows_q - (AW+1)'(1));
    assign last     = row_last && col_last;

    assign row_sel = AW'((int'(base_row_q) + int'(row_off)) % DIM);
    assign col_sel = AW'((int'(base_col_q) + int'(col_off)) % DIM);

    // Capture region on load; step row-major on advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            base_row_q <= '0;
            base_col_q <= '0;
            nrows_q    <= '0;
            ncols_q    <= '0;
            row_off    <= '0;
            col_off    <= '0;
        end else if (load) begin
            base_row_q <= base_row;
            base_col_q <= base_col;
            nrows_q    <= num_rows;
            ncols_q    <= num_cols;
            row_off    <= '0;
            col_off    <= '0;
        end else if (advance) begin
            if (col_last) begin
                col_off <= '0;
                row_off <= row_off + AW'(1);
            end else begin
                col_off <= col_off + AW'(1);
            end
        end
    end

endmodule

// File: rtl/pentary_weight_loader.sv
// Streams pentary digits into a crossbar region, one
// write per digit, paced by the controller's ready.
module pentary_weight_loader
    import pentary_pkg::*;
#(
    parameter int DIM = 256,
    parameter int AW  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [AW-1:0]        base_row,
    input  logic [AW-1:0]        base_col,
    input  logic [AW:0]          num_rows,
    input  logic [AW:0]          num_cols,
    pentary_weight_loader_if.slave s,
    output logic [AW-1:0]        xb_row_select,
    output logic [AW-1:0]        xb_col_select,
    output pent_t                xb_write_value,
    output logic                 xb_write_enable,
    input  logic                 xb_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 bad_pent,
    output logic [2*AW:0]        wr_count
);

    ld_state_t     state;
    ld_state_t     nxt;
    logic          load;
    logic          advance;
    logic          last;
    pent_t         val_q;
    logic          bad_q;
    logic [2*AW:0] cnt_q;

    pentary_region_addr_gen #(
        .DIM (DIM),
        .AW  (AW)
    ) u_addr (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .advance  (advance),
        .base_row (base_row),
        .base_col (base_col),
        .num_rows (num_rows),
        .num_cols (num_cols),
        .row_sel  (xb_row_select),
        .col_sel  (xb_col_select),
        .last     (last)
    );

    // Next-state and per-state strobes.
    always_comb begin
        nxt     = state;
        load    = 1'b0;
        advance = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    load = 1'b1;
                    if (num_rows == '0 || num_cols == '0)
                        nxt = ST_FIN;
                    else
                        nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (s.s_valid)
                    nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (xb_ready)
                    nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (xb_ready) begin
                    advance = 1'b1;
                    nxt     = last ? ST_FIN : ST_FETCH;
                end
            end
            ST_FIN: begin
                nxt = ST_IDLE;
            end
            default: begin
                nxt = ST_IDLE;
            end
        endcase
    end

    // State, latched digit, sticky error and write counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            val_q <= PENT_ZERO;
            bad_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            state <= nxt;
            if (load) begin
                bad_q <= 1'b0;
                cnt_q <= '0;
            end
            if (state == ST_FETCH && s.s_valid) begin
                if (pent_is_valid(s.s_pent)) begin
                    val_q <= s.s_pent;
                end else begin
                    val_q <= PENT_ZERO;
                    bad_q <= 1'b1;
                end
            end
            if (state == ST_ISSUE && xb_ready)
                cnt_q <= cnt_q + (2*AW+1)'(1);
        end
    end

    assign s.s_ready       = (state == ST_FETCH);
    assign xb_write_enable = (state == ST_ISSUE) && xb_ready && !reset;
    assign xb_write_value  = val_q;
    assign busy            = (state != ST_IDLE);
    assign done            = (state == ST_FIN);
    assign bad_pent        = bad_q;
    assign wr_count        = cnt_q;

endmodule

// File: tb/tb_pentary_weight_loader.sv
// Directed bench for pentary_weight_loader with a
// row-major write-list model and per-write compare.
module tb_pentary_weight_loader;
    import pentary_pkg::*;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] c;
        pent_t      v;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  base_row = '0;
    logic [7:0]  base_col = '0;
    logic [8:0]  num_rows = '0;
    logic [8:0]  num_cols = '0;
    logic [7:0]  xrow;
    logic [7:0]  xcol;
    pent_t       xval;
    logic        xwe;
    logic        xb_ready = 1'b1;
    logic        busy;
    logic        done;
    logic        bad_pent;
    logic [16:0] wr_count;

    int checks = 0;
    int errors = 0;

    wr_t   exp_q[$];
    pent_t stim_q[$];

    pentary_weight_loader_if s ();

    pentary_weight_loader dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .base_row        (base_row),
        .base_col        (base_col),
        .num_rows        (num_rows),
        .num_cols        (num_cols),
        .s               (s),
        .xb_row_select   (xrow),
        .xb_col_select   (xcol),
        .xb_write_value  (xval),
        .xb_write_enable (xwe),
        .xb_ready        (xb_ready),
        .busy            (busy),
        .done            (done),
        .bad_pent        (bad_pent),
        .wr_count        (wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected writes: every region cell in row-major order,
    // addresses modulo 256, illegal digits replaced by zero.
    task automatic build_model(input logic [7:0] br, input logic [7:0] bc,
                               input int nr, input int nc);
        wr_t w;
        pent_t d;
        exp_q.delete();
        for (int r = 0; r < nr; r++) begin
            for (int c = 0; c < nc; c++) begin
                d   = stim_q[r * nc + c];
                w.r = 8'((int'(br) + r) % 256);
                w.c = 8'((int'(bc) + c) % 256);
                w.v = (d <= 3'd4) ? d : 3'b010;
                exp_q.push_back(w);
            end
        end
    endtask

    // Every issued write must be the next one the model predicts.
    always @(negedge clk) begin
        if (xwe === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_write: got row %0h col %0h val %0h expected none",
                         xrow, xcol, xval);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                chk("write_row", xrow, w.r);
                chk("write_col", xcol, w.c);
                chk("write_val", xval, w.v);
            end
        end
    end

    task automatic reset_vals(input string p);
        chk({p, "_s_ready"}, s.s_ready, 0);
        chk({p, "_we"}, xwe, 0);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_done"}, done, 0);
        chk({p, "_bad"}, bad_pent, 0);
        chk({p, "_wr_count"}, wr_count, 0);
        chk({p, "_row"}, xrow, 0);
        chk({p, "_col"}, xcol, 0);
        chk({p, "_val"}, xval, 3'b010);
    endtask

    task automatic run_load(input string nm,
                            input logic [7:0] br, input logic [7:0] bc,
                            input logic [8:0] nr, input logic [8:0] nc,
                            input int exp_done, input int exp_cnt,
                            input logic exp_bad, input int stall_len,
                            input bit pulse_mid);
        int idx;
        int c;
        int done_cyc;
        bit hs;
        idx      = 0;
        done_cyc = -1;
        @(posedge clk);
        #1;
        start    = 1'b1;
        base_row = br;
        base_col = bc;
        num_rows = nr;
        num_cols = nc;
        s.s_valid = 1'b0;
        xb_ready = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        base_row = 8'hAA;
        base_col = 8'h55;
        num_rows = 9'd7;
        num_cols = 9'd7;
        s.s_valid = 1'b1;
        s.s_pent = (stim_q.size() > 0) ? stim_q[0] : PENT_ZERO;
        c = 1;
        while (c <= exp_done + 40) begin
            @(negedge clk);
            if (c == 1) begin
                chk({nm, "_bad_cleared"}, bad_pent, 0);
                chk({nm, "_s_ready_c1"}, s.s_ready, (nr != 0 && nc != 0));
            end
            if (stall_len > 0 && c >= 2 && c < 2 + stall_len) begin
                chk({nm, "_stall_we"}, xwe, 0);
                chk({nm, "_stall_busy"}, busy, 1);
            end
            hs = s.s_ready && s.s_valid;
            if (done) begin
                done_cyc = c;
                break;
            end
            @(posedge clk);
            #1;
            c++;
            if (hs) idx++;
            s.s_pent = (idx < stim_q.size()) ? stim_q[idx] : PENT_ZERO;
            xb_ready = !(c >= 2 && c < 2 + stall_len);
            if (pulse_mid) begin
                start    = (c == 4);
                num_cols = (c == 4) ? 9'd0 : 9'd7;
            end
        end
        chk({nm, "_done_cycle"}, done_cyc, exp_done);
        chk({nm, "_wr_count"}, wr_count, exp_cnt);
        chk({nm, "_bad_pent"}, bad_pent, exp_bad);
        chk({nm, "_pending_writes"}, exp_q.size(), 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        s.s_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_done_pulse"}, done, 0);
        chk({nm, "_idle"}, busy, 0);
        chk({nm, "_bad_sticky"}, bad_pent, exp_bad);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        s.s_valid = 1'b0;
        s.s_pent  = PENT_ZERO;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_vals("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        stim_q = '{PENT_POS2, PENT_POS1, PENT_ZERO,
                   PENT_NEG1, PENT_NEG2, PENT_POS1};
        build_model(8'd0, 8'd0, 2, 3);
        chk("model_first", exp_q[0], {8'd0, 8'd0, 3'b100});
        chk("model_last", exp_q[5], {8'd1, 8'd2, 3'b011});
        run_load("basic", 8'd0, 8'd0, 9'd2, 9'd3, 19, 6, 0, 0, 0);

        stim_q = '{PENT_NEG1, PENT_ZERO, PENT_POS1,
                   PENT_POS2, PENT_NEG2, PENT_ZERO};
        build_model(8'd255, 8'd254, 2, 3);
        chk("model_wrap_col", exp_q[2], {8'd255, 8'd0, 3'b011});
        chk("model_wrap_row", exp_q[3], {8'd0, 8'd254, 3'b100});
        run_load("wrap", 8'd255, 8'd254, 9'd2, 9'd3, 19, 6, 0, 0, 0);

        stim_q = '{PENT_POS1, 3'b111, PENT_NEG1};
        build_model(8'd10, 8'd20, 1, 3);
        chk("model_illegal", exp_q[1], {8'd10, 8'd21, 3'b010});
        run_load("illegal", 8'd10, 8'd20, 9'd1, 9'd3, 10, 3, 1, 0, 0);

        stim_q.delete();
        build_model(8'd3, 8'd3, 4, 0);
        run_load("zero", 8'd3, 8'd3, 9'd4, 9'd0, 1, 0, 0, 0, 0);

        stim_q = '{PENT_NEG2};
        build_model(8'd7, 8'd9, 1, 1);
        run_load("stall", 8'd7, 8'd9, 9'd1, 9'd1, 14, 1, 0, 10, 0);

        stim_q = '{PENT_POS2, PENT_NEG1};
        build_model(8'd100, 8'd200, 1, 2);
        run_load("start_busy", 8'd100, 8'd200, 9'd1, 9'd2, 7, 2, 0, 0, 1);

        stim_q = '{PENT_POS1, PENT_POS1};
        exp_q.delete();
        @(posedge clk);
        #1;
        start    = 1'b1;
        base_row = 8'd5;
        base_col = 8'd6;
        num_rows = 9'd1;
        num_cols = 9'd2;
        xb_ready = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        s.s_valid = 1'b1;
        s.s_pent  = PENT_POS1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_issue_we", xwe, 0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        s.s_valid = 1'b0;
        @(negedge clk);
        reset_vals("rst_mid");
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rst_no_done", done, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
